// File: rtl/picomips_pkg.sv
// picomips_pkg: shared opcodes, field widths, instruction word layout and loader states.
package picomips_pkg;
  localparam int OP_W = 6;
  localparam int REG_W = 3;
  localparam int IMM_W = 8;
  localparam int PSIZE_W = 5;
  localparam int WORD_W = OP_W + 2 * REG_W + IMM_W;
  localparam logic [OP_W-1:0] ADD = 6'd1;
  localparam logic [OP_W-1:0] ADDI = 6'd2;
  localparam logic [OP_W-1:0] MULI = 6'd3;
  localparam logic [OP_W-1:0] B = 6'd4;
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [IMM_W-1:0] imm;
  } instr_t;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ENC, S_WR, S_FULL, S_DONE, S_VERIFY, S_CHECK
  } loader_state_e;
endpackage

// File: rtl/picomips_instr_pack.sv
// picomips_instr_pack: forces unused fields per opcode, packs {op,rd,rs,imm}, flags illegal opcodes.
module picomips_instr_pack import picomips_pkg::*; #(
  parameter int OPW = OP_W,
  parameter int REGW = REG_W,
  parameter int IMMW = IMM_W
) (
  input  logic [OPW-1:0] op,
  input  logic [REGW-1:0] rd,
  input  logic [REGW-1:0] rs,
  input  logic [IMMW-1:0] imm,
  output logic [OPW+2*REGW+IMMW-1:0] word,
  output logic legal
);
  logic is_add, is_b;
  assign is_add = op == OPW'(ADD);
  assign is_b = op == OPW'(B);
  assign legal = is_add | is_b | (op == OPW'(ADDI)) | (op == OPW'(MULI));
  assign word = {op, is_b ? {REGW{1'b0}} : rd, is_b ? {REGW{1'b0}} : rs,
                 is_add ? {IMMW{1'b0}} : imm};
endmodule

// File: rtl/picomips_prog_loader.sv
// picomips_prog_loader: packs field bundles into instruction words and writes them to program memory.
// Optional PROG_LOADER_READBACK_EN adds pm_rdata and a read-back verify after every write.
module picomips_prog_loader import picomips_pkg::*; #(
  parameter int OPW = OP_W,
  parameter int REGW = REG_W,
  parameter int IMMW = IMM_W,
  parameter int PSIZE = PSIZE_W
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic finish,
  input  logic req_valid,
  output logic req_ready,
  input  logic [OPW-1:0] req_op,
  input  logic [REGW-1:0] req_rd,
  input  logic [REGW-1:0] req_rs,
  input  logic [IMMW-1:0] req_imm,
`ifdef PROG_LOADER_READBACK_EN
  input  logic [OPW+2*REGW+IMMW-1:0] pm_rdata,
`endif
  output logic pm_we,
  output logic [PSIZE-1:0] pm_addr,
  output logic [OPW+2*REGW+IMMW-1:0] pm_wdata,
  output logic [PSIZE:0] count,
  output logic err,
  output logic full,
  output logic done
);
  loader_state_e state, next;
  logic [PSIZE-1:0] wr_ptr;
  logic [OPW-1:0] f_op;
  logic [REGW-1:0] f_rd, f_rs;
  logic [IMMW-1:0] f_imm;
  logic [OPW+2*REGW+IMMW-1:0] word;
  logic legal;

  picomips_instr_pack #(.OPW(OPW), .REGW(REGW), .IMMW(IMMW)) u_pack (
    .op(f_op), .rd(f_rd), .rs(f_rs), .imm(f_imm), .word(word), .legal(legal)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= next;

  always_comb begin
    next = state;
    err = 1'b0;
    case (state)
      S_IDLE: next = start ? S_LOAD : S_IDLE;
      S_LOAD: next = finish ? S_DONE : req_valid ? S_ENC : S_LOAD;
      S_ENC: begin
        next = legal ? S_WR : S_LOAD;
        err = !legal;
      end
`ifdef PROG_LOADER_READBACK_EN
      S_WR: next = S_VERIFY;
      S_VERIFY: next = S_CHECK;
      S_CHECK: begin
        err = pm_rdata != pm_wdata;
        next = err ? S_DONE : count[PSIZE] ? S_FULL : S_LOAD;
      end
`else
      S_WR: next = (wr_ptr == '1) ? S_FULL : S_LOAD;
`endif
      S_FULL: next = finish ? S_DONE : S_FULL;
      S_DONE: next = start ? S_LOAD : S_DONE;
      default: next = S_IDLE;
    endcase
  end

  assign req_ready = state == S_LOAD;
  assign pm_we = state == S_WR;
  assign full = state == S_FULL;
  assign done = state == S_DONE;

  // wr_ptr parks on the last address instead of wrapping once memory is full
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      count <= '0;
      pm_addr <= '0;
      pm_wdata <= '0;
      f_op <= '0;
      f_rd <= '0;
      f_rs <= '0;
      f_imm <= '0;
    end else begin
      if (start && (state == S_IDLE || state == S_DONE)) begin
        wr_ptr <= '0;
        count <= '0;
      end
      if (state == S_LOAD && !finish && req_valid) begin
        f_op <= req_op;
        f_rd <= req_rd;
        f_rs <= req_rs;
        f_imm <= req_imm;
      end
      if (state == S_ENC && legal) begin
        pm_addr <= wr_ptr;
        pm_wdata <= word;
      end
      if (state == S_WR) begin
        if (wr_ptr != '1) wr_ptr <= wr_ptr + 1'b1;
        if (!count[PSIZE]) count <= count + 1'b1;
      end
    end
endmodule

// File: tb/tb_picomips_prog_loader.sv
// tb_picomips_prog_loader: directed checks of encoding, addressing, err, full, finish and reset.
module tb_picomips_prog_loader;
  logic clk = 0, reset = 1, start = 0, finish = 0, req_valid = 0;
  logic req_ready, pm_we, err, full, done;
  logic [5:0] req_op = '0;
  logic [2:0] req_rd = '0, req_rs = '0;
  logic [7:0] req_imm = '0;
  logic [4:0] pm_addr;
  logic [19:0] pm_wdata;
  logic [5:0] count;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  picomips_prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs(req_rs), .req_imm(req_imm),
`ifdef PROG_LOADER_READBACK_EN
    .pm_rdata(pm_wdata),
`endif
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata), .count(count),
    .err(err), .full(full), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ready"}, 32'(req_ready), 0);
    chk({tag, " we"}, 32'(pm_we), 0);
    chk({tag, " addr"}, 32'(pm_addr), 0);
    chk({tag, " wdata"}, 32'(pm_wdata), 0);
    chk({tag, " count"}, 32'(count), 0);
    chk({tag, " err"}, 32'(err), 0);
    chk({tag, " full"}, 32'(full), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // one legal request: handshake, ENC, WR, back in LOAD
  task automatic send(input string tag, input logic [5:0] op, input logic [2:0] rd,
                      input logic [2:0] rs, input logic [7:0] imm,
                      input logic [4:0] e_addr, input logic [19:0] e_word, input logic [5:0] e_cnt);
    chk({tag, " ready"}, 32'(req_ready), 1);
    req_op = op; req_rd = rd; req_rs = rs; req_imm = imm; req_valid = 1;
    tick();
    req_valid = 0;
    chk({tag, " we@enc"}, 32'(pm_we), 0);
    tick();
    chk({tag, " we@wr"}, 32'(pm_we), 1);
    chk({tag, " addr"}, 32'(pm_addr), 32'(e_addr));
    chk({tag, " wdata"}, 32'(pm_wdata), 32'(e_word));
    tick();
    chk({tag, " we after"}, 32'(pm_we), 0);
    chk({tag, " count"}, 32'(count), 32'(e_cnt));
  endtask

  initial begin
    tick();
    chk_zero("reset");
    reset = 0;
    tick();
    chk("idle ready", 32'(req_ready), 0);
    pulse_start();
    send("add", 6'd1, 3'd2, 3'd5, 8'hFF, 5'd0, {6'd1, 3'd2, 3'd5, 8'h00}, 6'd1);
    chk("hold wdata", 32'(pm_wdata), 32'({6'd1, 3'd2, 3'd5, 8'h00}));
    send("b", 6'd4, 3'd7, 3'd7, 8'h03, 5'd1, {6'd4, 3'd0, 3'd0, 8'h03}, 6'd2);
    req_op = 6'd9; req_rd = 3'd1; req_rs = 3'd1; req_imm = 8'h10; req_valid = 1;
    tick();
    req_valid = 0;
    chk("illegal err", 32'(err), 1);
    chk("illegal we", 32'(pm_we), 0);
    tick();
    chk("illegal err off", 32'(err), 0);
    chk("illegal we2", 32'(pm_we), 0);
    chk("illegal count", 32'(count), 2);
    chk("illegal ready", 32'(req_ready), 1);
    chk("illegal addr held", 32'(pm_addr), 1);
    finish = 1;
    tick();
    finish = 0;
    chk("finish done", 32'(done), 1);
    pulse_start();
    chk("restart count", 32'(count), 0);
    chk("restart done", 32'(done), 0);
    for (int i = 0; i < 32; i++)
      send($sformatf("addi%0d", i), 6'd2, 3'(i), 3'(~i), 8'(i * 3), 5'(i),
           {6'd2, 3'(i), 3'(~i), 8'(i * 3)}, 6'(i + 1));
    chk("full flag", 32'(full), 1);
    chk("full ready", 32'(req_ready), 0);
    chk("full count", 32'(count), 32);
    chk("full addr", 32'(pm_addr), 31);
    req_op = 6'd2; req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall we", 32'(pm_we), 0);
      chk("stall ready", 32'(req_ready), 0);
    end
    req_valid = 0;
    chk("stall count", 32'(count), 32);
    finish = 1;
    tick();
    finish = 0;
    chk("full->done", 32'(done), 1);
    chk("full cleared", 32'(full), 0);
    pulse_start();
    req_op = 6'd2; req_rd = 3'd3; req_rs = 3'd4; req_imm = 8'h55;
    req_valid = 1; finish = 1;
    tick();
    req_valid = 0; finish = 0;
    chk("coinc done", 32'(done), 1);
    chk("coinc ready", 32'(req_ready), 0);
    tick();
    chk("coinc we", 32'(pm_we), 0);
    chk("coinc count", 32'(count), 0);
    pulse_start();
    send("after restart", 6'd3, 3'd6, 3'd1, 8'hA5, 5'd0, {6'd3, 3'd6, 3'd1, 8'hA5}, 6'd1);
    req_op = 6'd1; req_rd = 3'd4; req_rs = 3'd4; req_imm = 8'h77; req_valid = 1;
    tick();
    req_valid = 0;
    chk("pre-reset wdata", 32'(pm_wdata), 32'({6'd3, 3'd6, 3'd1, 8'hA5}));
    reset = 1;
    #1;
    chk_zero("async reset");
    tick();
    chk("reset we", 32'(pm_we), 0);
    reset = 0;
    tick();
    chk_zero("post reset idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
